// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Sequencer state encoding
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] EX_WAIT = 1'b1;

  // Register $zero never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Which condition owns the pipeline controls this cycle, highest priority first
  typedef enum logic [2:0] {
    RSN_RESET   = 3'd0,
    RSN_MEMBUSY = 3'd1,
    RSN_MULDIV  = 3'd2,
    RSN_LOADUSE = 3'd3,
    RSN_BRANCH  = 3'd4,
    RSN_NONE    = 3'd5
  } reason_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       stall_req
);

  logic rsMatch;
  logic rtMatch;

  // A load into $zero produces nothing worth waiting for
  always_comb begin
    rsMatch   = (ex_rt == id_rs);
    rtMatch   = id_uses_rt && (ex_rt == id_rt);
    stall_req = ex_mem_read && (ex_rt != REG_ZERO) && (rsMatch || rtMatch);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves memory
// wait states, mult/div occupancy of EX, load-use hazards and taken branches,
// and keeps stall/flush counters plus a sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_multicycle,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             ex_mem_bubble,
  output logic             mem_wb_write,
  output logic             muldiv_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // The freeze cycle in RUN accounts for one EX cycle and the release cycle
  // in EX_WAIT for another, so the wait counter starts two below the latency.
  localparam bit         HAS_FREEZE = (MULDIV_LAT >= 2);
  localparam logic [4:0] WAIT_INIT  = HAS_FREEZE ? 5'(MULDIV_LAT - 2) : 5'd0;
  localparam int         TO_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

  logic [0:0]      state;
  logic [4:0]      wcnt;
  logic [TO_W-1:0] busyCnt;
  logic            loadUseReq;
  logic            muldivFreeze;
  reason_t         reason;

  load_use_detect uLoadUse (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .stall_req   (loadUseReq)
  );

  // Pick the single highest-priority condition owning the controls this cycle
  always_comb begin
    muldivFreeze = ((state == RUN) && ex_multicycle && HAS_FREEZE) ||
                   ((state == EX_WAIT) && (wcnt != 5'd0));
    reason = RSN_NONE;
    if (reset)
      reason = RSN_RESET;
    else if (mem_busy)
      reason = RSN_MEMBUSY;
    else if (muldivFreeze)
      reason = RSN_MULDIV;
    else if ((state == RUN) && loadUseReq)
      reason = RSN_LOADUSE;
    else if (id_branch_taken)
      reason = RSN_BRANCH;
  end

  // Decode the winning condition into register enables, bubbles and flush
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_write  = 1'b1;
    case (reason)
      RSN_RESET, RSN_MEMBUSY: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end
      RSN_MULDIV: begin
        // Front end and EX hold; a bubble goes to MEM so older work drains
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
      end
      RSN_LOADUSE: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      RSN_BRANCH:  if_id_flush = 1'b1;
      default:     ;
    endcase
    muldiv_busy = (state == EX_WAIT);
  end

  // Mult/div occupancy sequencer; memory wait states freeze it in place
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wcnt  <= 5'd0;
    end else if (!mem_busy) begin
      if (state == RUN) begin
        if (ex_multicycle && HAS_FREEZE) begin
          state <= EX_WAIT;
          wcnt  <= WAIT_INIT;
        end
      end else if (wcnt != 5'd0) begin
        wcnt <= wcnt - 5'd1;
      end else begin
        state <= RUN;
      end
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  // Consecutive mem_busy tracker; the flag latches once the run hits the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      busyCnt     <= '0;
      mem_timeout <= 1'b0;
    end else if (!mem_busy) begin
      busyCnt <= '0;
    end else if (busyCnt != TO_MAX) begin
      busyCnt <= busyCnt + TO_W'(1);
      if (busyCnt == TO_MAX - TO_W'(1))
        mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MULDIV_LAT=4, MEM_TIMEOUT=16).
module tb_pipeline_hazard_ctrl;

  // Control word order: {pc, if_id_w, if_id_flush, id_ex_w, id_ex_bubble, ex_mem_w, ex_mem_bubble, mem_wb_w}
  localparam logic [7:0] C_DEF  = 8'b1101_0101;
  localparam logic [7:0] C_ALL0 = 8'b0000_0000;
  localparam logic [7:0] C_FRZ  = 8'b0000_0111;
  localparam logic [7:0] C_LU   = 8'b0001_1101;
  localparam logic [7:0] C_BR   = 8'b1111_0101;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic        busy;
    logic        tmo;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_branch_taken, ex_mem_read, ex_multicycle, mem_busy;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic        ex_mem_write, ex_mem_bubble, mem_wb_write, muldiv_busy, mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  exp_t expQ[$];
  int   nVec = 0;
  int   nBad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(4), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_multicycle(ex_multicycle), .mem_busy(mem_busy), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_write(mem_wb_write), .muldiv_busy(muldiv_busy), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Drive one cycle of inputs just after the edge and queue its expected response
  task automatic vec(input string nm, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic usesRt, input logic br, input logic memRd, input logic [4:0] exRt,
                     input logic mc, input logic busy, input logic [7:0] eCtl, input logic eBusy,
                     input logic eTmo, input int eStall, input int eFlush);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = usesRt; id_branch_taken = br;
    ex_mem_read = memRd; ex_rt = exRt; ex_multicycle = mc; mem_busy = busy;
    e.name = nm; e.ctl = eCtl; e.busy = eBusy; e.tmo = eTmo;
    e.stall = 32'(eStall); e.flush = 32'(eFlush);
    expQ.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, ex_mem_bubble, mem_wb_write};
        nVec++;
        if (act !== e.ctl || muldiv_busy !== e.busy || mem_timeout !== e.tmo ||
            stall_cycles !== e.stall || flush_count !== e.flush) begin
          nBad++;
          $display("FAIL %s: got ctl=%b busy=%b tmo=%b stall=%0d flush=%0d, want ctl=%b busy=%b tmo=%b stall=%0d flush=%0d",
                   e.name, act, muldiv_busy, mem_timeout, stall_cycles, flush_count,
                   e.ctl, e.busy, e.tmo, e.stall, e.flush);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_rt = '0; ex_multicycle = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);

    //   name         rst rs    rt    ur br mr exRt  mc bz  ctl     mb to stall flush
    vec("reset",      1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_ALL0, 0, 0, 0, 0);
    vec("idle0",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 0, 0);
    // load-use on rs, one cycle only
    vec("lu_rs",      0, 5'd8, 5'd0, 0, 0, 1, 5'd8, 0, 0, C_LU,   0, 0, 0, 0);
    vec("lu_after",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 1, 0);
    // $zero and unused rt never stall; used rt does
    vec("lu_zero",    0, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, C_DEF,  0, 0, 1, 0);
    vec("lu_rt_nouse",0, 5'd1, 5'd9, 0, 0, 1, 5'd9, 0, 0, C_DEF,  0, 0, 1, 0);
    vec("lu_rt_use",  0, 5'd1, 5'd9, 1, 0, 1, 5'd9, 0, 0, C_LU,   0, 0, 1, 0);
    vec("idle1",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 2, 0);
    // taken branch alone, then together with a load-use hazard
    vec("branch",     0, 5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, C_BR,   0, 0, 2, 0);
    vec("br_after",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 2, 1);
    vec("br_lu",      0, 5'd8, 5'd0, 0, 1, 1, 5'd8, 0, 0, C_LU,   0, 0, 2, 1);
    vec("br_lu_after",0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 3, 1);
    // mult/div occupancy: 3 frozen cycles then advance; branch ignored while frozen
    vec("md_reset",   1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_ALL0, 0, 0, 3, 1);
    vec("md_c1",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_FRZ,  0, 0, 0, 0);
    vec("md_c2_br",   0, 5'd0, 5'd0, 0, 1, 0, 5'd0, 1, 0, C_FRZ,  1, 0, 1, 0);
    vec("md_c3",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_FRZ,  1, 0, 2, 0);
    vec("md_c4",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_DEF,  1, 0, 3, 0);
    vec("md_run",     0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 3, 0);
    // mem_busy in the middle of EX_WAIT holds the wait count
    vec("mb_c1",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_FRZ,  0, 0, 3, 0);
    vec("mb_c2",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_FRZ,  1, 0, 4, 0);
    vec("mb_busy1",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, C_ALL0, 1, 0, 5, 0);
    vec("mb_busy2",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, C_ALL0, 1, 0, 6, 0);
    vec("mb_busy3",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, C_ALL0, 1, 0, 7, 0);
    vec("mb_c3",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_FRZ,  1, 0, 8, 0);
    vec("mb_c4",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_DEF,  1, 0, 9, 0);
    vec("mb_run",     0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 9, 0);
    // reset aborts an in-progress wait
    vec("ra_c1",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_FRZ,  0, 0, 9, 0);
    vec("ra_c2",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_FRZ,  1, 0, 10, 0);
    vec("ra_reset",   1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, C_ALL0, 1, 0, 11, 0);
    vec("ra_after",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 0, 0);
    // memory timeout: 16 busy cycles, first one also carrying load-use and branch
    vec("to_b1",      0, 5'd8, 5'd0, 0, 1, 1, 5'd8, 0, 1, C_ALL0, 0, 0, 0, 0);
    for (int i = 1; i < 16; i++)
      vec($sformatf("to_b%0d", i + 1), 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, C_ALL0, 0, 0, i, 0);
    vec("to_set",     0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 1, 16, 0);
    vec("to_busy",    0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, C_ALL0, 0, 1, 16, 0);
    vec("to_sticky",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 1, 17, 0);
    vec("to_reset",   1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_ALL0, 0, 1, 17, 0);
    vec("to_clear",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_DEF,  0, 0, 0, 0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      nVec++;
      nBad++;
      $display("FAIL drain: %0d entries left, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
